mod_exp_sequencer: RTL and testbench

//  Initiator side of the modular-product start/done interface. Computes y^d mod N by

---
 rtl/mod_exp_sequencer.sv | 135 +++++++++++++
 tb/tb_mod_exp_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_sequencer.sv
// Right-to-left binary modular exponentiation sequencer: drives an external
// a*b mod N multiplier through a start/done handshake and returns y^d mod N.
module mod_exp_sequencer #(
  parameter int WIDTH = 256,
  parameter int KW    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_mp_start,
  output logic [WIDTH:0]   o_mp_a,
  output logic [WIDTH:0]   o_mp_b,
  output logic [WIDTH:0]   o_mp_n,
  output logic [KW-1:0]    o_mp_k,
  input  logic [WIDTH-1:0] i_mp_result,
  input  logic             i_mp_done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    ISSUE_M,
    WAIT_M,
    ISSUE_T,
    WAIT_T,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] t;
  logic [BW-1:0]    bit_idx;

  assign o_mp_k = KW'(WIDTH);

  // m accumulates the product of selected powers, t holds y^(2^bit_idx).
  // Outputs are registered on the transition into the state that presents them,
  // so o_mp_start is high exactly during the ISSUE_* cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      d          <= '0;
      m          <= '0;
      t          <= '0;
      bit_idx    <= '0;
      o_result   <= '0;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
      o_mp_start <= 1'b0;
      o_mp_a     <= '0;
      o_mp_b     <= '0;
      o_mp_n     <= '0;
    end else begin
      o_done     <= 1'b0;
      o_mp_start <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            d       <= i_d;
            m       <= WIDTH'(1);
            t       <= i_y;
            bit_idx <= '0;
            o_mp_n  <= {1'b0, i_n};
            o_busy  <= 1'b1;
            state   <= CHK;
          end
        end

        CHK: begin
          if (d[bit_idx]) begin
            o_mp_a     <= {1'b0, m};
            o_mp_b     <= {1'b0, t};
            o_mp_start <= 1'b1;
            state      <= ISSUE_M;
          end else if (bit_idx == LAST_BIT) begin
            o_result <= m;
            o_done   <= 1'b1;
            o_busy   <= 1'b0;
            state    <= DONE;
          end else begin
            o_mp_a     <= {1'b0, t};
            o_mp_b     <= {1'b0, t};
            o_mp_start <= 1'b1;
            state      <= ISSUE_T;
          end
        end

        ISSUE_M: state <= WAIT_M;

        // The final squaring would be wasted work, so the last bit ends here.
        WAIT_M: begin
          if (i_mp_done) begin
            m <= i_mp_result;
            if (bit_idx == LAST_BIT) begin
              o_result <= i_mp_result;
              o_done   <= 1'b1;
              o_busy   <= 1'b0;
              state    <= DONE;
            end else begin
              o_mp_a     <= {1'b0, t};
              o_mp_b     <= {1'b0, t};
              o_mp_start <= 1'b1;
              state      <= ISSUE_T;
            end
          end
        end

        ISSUE_T: state <= WAIT_T;

        WAIT_T: begin
          if (i_mp_done) begin
            t       <= i_mp_result;
            bit_idx <= bit_idx + 1'b1;
            state   <= CHK;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_sequencer.sv
// Scoreboard bench for mod_exp_sequencer: behavioural multipliers with fixed
// latency, reference exponentiation by plain arithmetic, WIDTH=8 and WIDTH=256.
module tb_mod_exp_sequencer;

  localparam int W  = 8;
  localparam int WB = 256;
  localparam int KW = 11;
  localparam int L  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [W-1:0]  y, d, n;
  logic [W-1:0]  result;
  logic          done, busy, mp_start;
  logic [W:0]    mp_a, mp_b, mp_n;
  logic [KW-1:0] mp_k;
  logic [W-1:0]  mp_result;
  logic          mp_done;

  logic          b_start;
  logic [WB-1:0] b_y, b_d, b_n;
  logic [WB-1:0] b_result;
  logic          b_done, b_busy, b_mp_start;
  logic [WB:0]   b_mp_a, b_mp_b, b_mp_n;
  logic [KW-1:0] b_mp_k;
  logic [WB-1:0] b_mp_result;
  logic          b_mp_done;

  mod_exp_sequencer #(.WIDTH(W), .KW(KW)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_y(y), .i_d(d), .i_n(n),
    .o_result(result), .o_done(done), .o_busy(busy), .o_mp_start(mp_start),
    .o_mp_a(mp_a), .o_mp_b(mp_b), .o_mp_n(mp_n), .o_mp_k(mp_k),
    .i_mp_result(mp_result), .i_mp_done(mp_done)
  );

  mod_exp_sequencer #(.WIDTH(WB), .KW(KW)) dut_big (
    .clk(clk), .rst(rst), .i_start(b_start), .i_y(b_y), .i_d(b_d), .i_n(b_n),
    .o_result(b_result), .o_done(b_done), .o_busy(b_busy), .o_mp_start(b_mp_start),
    .o_mp_a(b_mp_a), .o_mp_b(b_mp_b), .o_mp_n(b_mp_n), .o_mp_k(b_mp_k),
    .i_mp_result(b_mp_result), .i_mp_done(b_mp_done)
  );

  typedef struct {
    logic [WB-1:0] res;
    int            pulses;
    bit            all_sq;
  } exp_t;

  exp_t sb_q[$];
  exp_t b_q[$];

  int checks = 0;
  int errors = 0;

  int pulse_cnt = 0, nonsq_cnt = 0, b_pulse_cnt = 0;
  bit spurious_en = 1'b0;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference: exponent as repeated multiplication, reduced each step.
  function automatic logic [W-1:0] ref_pow8(input logic [W-1:0] by, input logic [W-1:0] bd,
                                            input logic [W-1:0] bn);
    int unsigned r;
    r = 1;
    for (int i = 0; i < 32'(bd); i++) r = (r * 32'(by)) % 32'(bn);
    return r[W-1:0];
  endfunction

  // Reference: left-to-right square-and-multiply on wide integers.
  function automatic logic [WB-1:0] ref_pow256(input logic [WB-1:0] by, input logic [WB-1:0] bd,
                                               input logic [WB-1:0] bn);
    logic [511:0] r, yy, nn;
    r  = 512'd1;
    yy = {256'd0, by};
    nn = {256'd0, bn};
    for (int i = WB - 1; i >= 0; i--) begin
      r = (r * r) % nn;
      if (bd[i]) r = (r * yy) % nn;
    end
    return r[WB-1:0];
  endfunction

  // Behavioural multiplier for the 8-bit DUT, optional spurious done pulses.
  initial begin
    int pend;
    logic [W:0] ca, cb, cn;
    pend = 0;
    ca = '0; cb = '0; cn = '0;
    mp_done = 1'b0;
    mp_result = '0;
    forever begin
      @(negedge clk);
      mp_done = 1'b0;
      if (rst) begin
        pend = 0;
        pulse_cnt = 0;
        nonsq_cnt = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            checkOutput("mp_operands_held", {mp_a, mp_b, mp_n}, {ca, cb, cn});
            mp_result = W'((18'(ca) * 18'(cb)) % 18'(cn));
            mp_done = 1'b1;
          end
        end else if (!mp_start && spurious_en && $urandom_range(0, 2) == 0) begin
          mp_result = W'($urandom);
          mp_done = 1'b1;
        end
        if (mp_start) begin
          checkOutput("one_outstanding", 512'(pend), 512'd0);
          ca = mp_a; cb = mp_b; cn = mp_n;
          pend = L - 1;
          pulse_cnt++;
          if (mp_a != mp_b) nonsq_cnt++;
        end
      end
    end
  end

  // Behavioural multiplier for the 256-bit DUT.
  initial begin
    int pend;
    logic [513:0] prod;
    logic [WB:0] ca, cb, cn;
    pend = 0;
    ca = '0; cb = '0; cn = '0;
    b_mp_done = 1'b0;
    b_mp_result = '0;
    forever begin
      @(negedge clk);
      b_mp_done = 1'b0;
      if (rst) begin
        pend = 0;
        b_pulse_cnt = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            prod = (514'(ca) * 514'(cb)) % 514'(cn);
            b_mp_result = prod[WB-1:0];
            b_mp_done = 1'b1;
          end
        end
        if (b_mp_start) begin
          ca = b_mp_a; cb = b_mp_b; cn = b_mp_n;
          pend = L - 1;
          b_pulse_cnt++;
        end
      end
    end
  end

  // Monitor for the 8-bit DUT: pops the scoreboard on every o_done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got o_done=1 expected none, result %0h", result);
        end else begin
          e = sb_q.pop_front();
          checkOutput("result", 512'(result), 512'(e.res));
          checkOutput("busy_at_done", 512'(busy), 512'd0);
          checkOutput("request_count", 512'(pulse_cnt), 512'(e.pulses));
          if (e.all_sq) checkOutput("all_squarings", 512'(nonsq_cnt), 512'd0);
        end
        pulse_cnt = 0;
        nonsq_cnt = 0;
      end
    end
  end

  // Monitor for the 256-bit DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && b_done) begin
        if (b_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL big_unexpected_done: got o_done=1 expected none");
        end else begin
          e = b_q.pop_front();
          checkOutput("big_result", 512'(b_result), 512'(e.res));
          checkOutput("big_request_count", 512'(b_pulse_cnt), 512'(e.pulses));
        end
        b_pulse_cnt = 0;
      end
    end
  end

  task automatic waitIdle(input logic [W-1:0] exp_res);
    int cyc;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 4000) begin
      tick();
      cyc++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no o_done in %0d cycles expected o_done", cyc);
      sb_q.delete();
    end else begin
      tick();
      checkOutput("result_held", 512'(result), 512'(exp_res));
      checkOutput("done_single_cycle", 512'(done), 512'd0);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] ay, input logic [W-1:0] ad,
                               input logic [W-1:0] an, input bit chk_sq);
    exp_t e;
    e.res    = WB'(ref_pow8(ay, ad, an));
    e.pulses = $countones(ad) + W - 1;
    e.all_sq = chk_sq;
    start = 1'b1; y = ay; d = ad; n = an;
    sb_q.push_back(e);
    tick();
    start = 1'b0;
    y = W'($urandom); d = W'($urandom); n = W'($urandom);
    checkOutput("busy_after_start", 512'(busy), 512'd1);
    waitIdle(e.res[W-1:0]);
  endtask

  initial begin
    exp_t e;
    int cyc;
    rst = 1'b1;
    start = 1'b0; y = '0; d = '0; n = '0;
    b_start = 1'b0; b_y = '0; b_d = '0; b_n = '0;
    repeat (2) tick();
    checkOutput("reset_result", 512'(result), 512'd0);
    checkOutput("reset_busy", 512'(busy), 512'd0);
    checkOutput("reset_done", 512'(done), 512'd0);
    checkOutput("reset_mp_start", 512'(mp_start), 512'd0);
    checkOutput("reset_mp_ab", 512'({mp_a, mp_b, mp_n}), 512'd0);
    checkOutput("mp_k", 512'(mp_k), 512'd8);
    checkOutput("big_mp_k", 512'(b_mp_k), 512'd256);
    rst = 1'b0;
    tick();

    $display("[TB] basic exponentiation");
    applyStimulus(8'd5, 8'd3, 8'd13, 1'b0);
    applyStimulus(8'd7, 8'd0, 8'd11, 1'b1);

    $display("[TB] i_start while busy");
    e.res = WB'(8); e.pulses = 9; e.all_sq = 1'b0;
    start = 1'b1; y = 8'd5; d = 8'd3; n = 8'd13;
    sb_q.push_back(e);
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; y = 8'd2; d = 8'd5; n = 8'd13;
    tick();
    start = 1'b0;
    checkOutput("busy_during_op", 512'(busy), 512'd1);
    waitIdle(8'd8);

    $display("[TB] reset during WAIT_T");
    e.res = WB'(8); e.pulses = 9; e.all_sq = 1'b0;
    start = 1'b1; y = 8'd5; d = 8'd3; n = 8'd13;
    sb_q.push_back(e);
    tick();
    start = 1'b0;
    cyc = 0;
    while (pulse_cnt < 2 && cyc < 100) begin
      tick();
      cyc++;
    end
    checkOutput("reached_wait_t", 512'(pulse_cnt), 512'd2);
    rst = 1'b1;
    sb_q.delete();
    tick();
    checkOutput("midrst_result", 512'(result), 512'd0);
    checkOutput("midrst_busy", 512'(busy), 512'd0);
    checkOutput("midrst_done", 512'(done), 512'd0);
    checkOutput("midrst_mp_start", 512'(mp_start), 512'd0);
    checkOutput("midrst_mp_abn", 512'({mp_a, mp_b, mp_n}), 512'd0);
    rst = 1'b0;
    repeat (10) tick();
    checkOutput("idle_after_rst", 512'(busy), 512'd0);
    applyStimulus(8'd3, 8'd4, 8'd7, 1'b0);

    $display("[TB] spurious multiplier done pulses");
    spurious_en = 1'b1;
    applyStimulus(8'd5, 8'd3, 8'd13, 1'b0);

    $display("[TB] randomized operands");
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] rn, ry, rd;
      rn = W'($urandom_range(2, 255));
      ry = W'($urandom_range(0, 32'(rn) - 1));
      rd = W'($urandom);
      spurious_en = $urandom_range(0, 1) == 1;
      applyStimulus(ry, rd, rn, rd == 0);
    end
    spurious_en = 1'b0;

    $display("[TB] 256-bit y=2 d=65537");
    for (int i = 0; i < 8; i++) b_n[i*32 +: 32] = $urandom;
    b_n[WB-1] = 1'b1;
    b_n[0] = 1'b1;
    e.res = ref_pow256(256'd2, 256'd65537, b_n);
    e.pulses = 2 + WB - 1;
    e.all_sq = 1'b0;
    b_y = 256'd2; b_d = 256'd65537;
    b_start = 1'b1;
    b_q.push_back(e);
    tick();
    b_start = 1'b0;
    b_y = '0; b_d = '0;
    cyc = 0;
    while (b_q.size() != 0 && cyc < 5000) begin
      tick();
      cyc++;
    end
    if (b_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL big_done_timeout: got no o_done in %0d cycles expected o_done", cyc);
      b_q.delete();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
